lc3b_mem_arbiter: RTL and testbench

// - Shares the single physical memory port between the instruction-fetch requester and the data requester.
//   The data requester is the load/store/TRAP side of the lc3b control FSM.
// - Registered grant; round-robin or fixed priority; one transaction in flight at a time.
// - Watchdog flags a memory that never returns mem_resp.
// - Sits between the CPU (control + datapath) and the memory model / cache.

---
 rtl/lc3b_mem_arbiter_pkg.sv | 17 +
 rtl/lc3b_mem_arbiter_if.sv | 34 +++
 rtl/lc3b_mem_arbiter_watchdog.sv | 43 ++++
 rtl/lc3b_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_lc3b_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_mem_arbiter_pkg.sv
// lc3b_types: shared LC-3b word/mask types plus the memory-arbiter port id.
// No ports; imported by the arbiter, its interface and the bench.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    // Identifies which requester owns the memory port.
    typedef enum logic {
        arb_i = 1'b0,
        arb_d = 1'b1
    } lc3b_arb_port;

    // Reads always fetch the whole word.
    localparam lc3b_mem_wmask MEM_BE_ALL = 2'b11;

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// lc3b_mem_arbiter_if: one memory-style request/response port.
// Signals: read, write, wmask, address, wdata (request side),
//          rdata, resp (response side).
// Modports:
//   master      - issues requests (the arbiter towards memory)
//   slave       - serves full read/write requests (the arbiter's data port)
//   fetch_slave - serves read-only requests (the arbiter's fetch port)
interface lc3b_mem_arbiter_if;
    import lc3b_types::*;

    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_word      rdata;
    logic          resp;

    modport master (
        output read, write, wmask, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, wmask, address, wdata,
        output rdata, resp
    );

    modport fetch_slave (
        input  read, address,
        output rdata, resp
    );

endinterface

// File: rtl/lc3b_mem_arbiter_watchdog.sv
// lc3b_watchdog: saturating cycle counter with a sticky limit flag.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   clear      - zero the counter (start of a new grant)
//   enable     - count this cycle (granted, no response yet)
//   flag       - sticky; sets when an enabled cycle sees count == LIMIT-1
module lc3b_watchdog #(
    parameter int LIMIT = 32'sd256,
    parameter int CNT_W = 32'sd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic flag
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 32'sd1);

    logic [CNT_W-1:0] cnt_r;
    logic             flag_r;

    // Counter and sticky flag; only reset can drop the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            flag_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == LIMIT_M1) begin
                flag_r <= 1'b1;
            end
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign flag = flag_r;

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one memory port between instruction fetch and
// the data (load/store/TRAP) side of the CPU. One transaction at a time.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   i_port       - fetch requester (read only)
//   d_port       - data requester (read or write with byte mask)
//   mem          - towards memory / cache
//   busy         - 1 while a port holds the grant
//   err_timeout  - sticky: memory held a grant TIMEOUT_CYCLES cycles without resp
module lc3b_mem_arbiter
    import lc3b_types::*;
#(
    parameter bit RR_ENABLE      = 1'b1,
    parameter int TIMEOUT_CYCLES = 32'sd256,
    parameter int CNT_W          = 32'sd9
) (
    input  logic                            clk,
    input  logic                            rst_n,
    lc3b_mem_arbiter_if.fetch_slave         i_port,
    lc3b_mem_arbiter_if.slave               d_port,
    lc3b_mem_arbiter_if.master              mem,
    output logic                            busy,
    output logic                            err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GNT_I = 2'b01,
        S_GNT_D = 2'b10
    } state_e;

    state_e       state_r;
    lc3b_arb_port last_gnt_r;
    lc3b_arb_port pick_s;
    logic         i_req_s;
    logic         d_req_s;
    logic         wd_clear_s;
    logic         wd_enable_s;

    // On a collision round-robin hands the port to whoever did not have it
    // last; fixed priority always favours the data side.
    function automatic lc3b_arb_port pick_port(input logic         i_req,
                                               input logic         d_req,
                                               input lc3b_arb_port last);
        lc3b_arb_port p;
        p = arb_i;
        if (i_req && d_req) begin
            if (RR_ENABLE) begin
                p = (last == arb_i) ? arb_d : arb_i;
            end else begin
                p = arb_d;
            end
        end else if (d_req) begin
            p = arb_d;
        end else begin
            p = arb_i;
        end
        return p;
    endfunction

    assign i_req_s = i_port.read;
    assign d_req_s = d_port.read | d_port.write;
    assign pick_s  = pick_port(i_req_s, d_req_s, last_gnt_r);

    // Grant FSM; a grant ends on mem_resp or when the owner withdraws.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            last_gnt_r <= arb_i;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_req_s || d_req_s) begin
                        state_r    <= (pick_s == arb_d) ? S_GNT_D : S_GNT_I;
                        last_gnt_r <= pick_s;
                    end
                end
                S_GNT_I: begin
                    if (mem.resp || !i_req_s) begin
                        state_r <= S_IDLE;
                    end
                end
                S_GNT_D: begin
                    if (mem.resp || !d_req_s) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Memory and response steering decoded from the registered state, so a
    // reset drops everything in the same cycle.
    always_comb begin
        mem.read      = 1'b0;
        mem.write     = 1'b0;
        mem.wmask     = MEM_BE_ALL;
        mem.address   = 16'h0000;
        mem.wdata     = 16'h0000;
        i_port.resp   = 1'b0;
        d_port.resp   = 1'b0;
        case (state_r)
            S_GNT_I: begin
                mem.read    = i_port.read;
                mem.address = i_port.address;
                i_port.resp = mem.resp;
            end
            S_GNT_D: begin
                mem.read    = d_port.read;
                mem.write   = d_port.write;
                mem.address = d_port.address;
                mem.wdata   = d_port.wdata;
                mem.wmask   = d_port.write ? d_port.wmask : MEM_BE_ALL;
                d_port.resp = mem.resp;
            end
            default: begin
                // Idle: memory outputs stay quiet and stray resp is dropped.
                mem.read = 1'b0;
            end
        endcase
    end

    assign i_port.rdata = mem.rdata;
    assign d_port.rdata = mem.rdata;
    assign busy         = (state_r != S_IDLE);

    // Counter restarts on the grant edge and runs while the grant waits.
    assign wd_clear_s  = (state_r == S_IDLE) && (i_req_s || d_req_s);
    assign wd_enable_s = busy && !mem.resp;

    lc3b_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear_s),
        .enable (wd_enable_s),
        .flag   (err_timeout)
    );

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Scoreboard bench for lc3b_mem_arbiter. Unit 0: round-robin, TIMEOUT_CYCLES=8.
// Unit 1: fixed priority. Memory models return rdata = address ^ 16'h2234.
module tb_lc3b_mem_arbiter;
    import lc3b_types::*;

    typedef struct {
        bit            d;
        bit            wr;
        lc3b_word      addr;
        lc3b_mem_wmask be;
        lc3b_word      wdata;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    logic busy0, err0, busy1, err1;

    lc3b_mem_arbiter_if if_i0();
    lc3b_mem_arbiter_if if_d0();
    lc3b_mem_arbiter_if if_m0();
    lc3b_mem_arbiter_if if_i1();
    lc3b_mem_arbiter_if if_d1();
    lc3b_mem_arbiter_if if_m1();

    lc3b_mem_arbiter #(.RR_ENABLE(1'b1), .TIMEOUT_CYCLES(8), .CNT_W(9)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_port(if_i0), .d_port(if_d0), .mem(if_m0),
        .busy(busy0), .err_timeout(err0)
    );

    lc3b_mem_arbiter #(.RR_ENABLE(1'b0), .TIMEOUT_CYCLES(256), .CNT_W(9)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_port(if_i1), .d_port(if_d1), .mem(if_m1),
        .busy(busy1), .err_timeout(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model 0: responds lat0 cycles into an access when m_en is set.
    logic       m0_resp_r;
    logic [7:0] m0_cnt_r;
    logic       m_en;
    logic       stray;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_resp_r <= 1'b0;
            m0_cnt_r  <= 8'd0;
        end else begin
            m0_resp_r <= 1'b0;
            if ((if_m0.read || if_m0.write) && !m0_resp_r && m_en) begin
                if (m0_cnt_r == 8'd2) begin
                    m0_resp_r <= 1'b1;
                    m0_cnt_r  <= 8'd0;
                end else begin
                    m0_cnt_r <= m0_cnt_r + 8'd1;
                end
            end else begin
                m0_cnt_r <= 8'd0;
            end
        end
    end
    assign if_m0.resp  = m0_resp_r | stray;
    assign if_m0.rdata = if_m0.address ^ 16'h2234;

    // Memory model 1: fixed two-cycle latency.
    logic       m1_resp_r;
    logic [7:0] m1_cnt_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_resp_r <= 1'b0;
            m1_cnt_r  <= 8'd0;
        end else begin
            m1_resp_r <= 1'b0;
            if ((if_m1.read || if_m1.write) && !m1_resp_r) begin
                if (m1_cnt_r == 8'd1) begin
                    m1_resp_r <= 1'b1;
                    m1_cnt_r  <= 8'd0;
                end else begin
                    m1_cnt_r <= m1_cnt_r + 8'd1;
                end
            end else begin
                m1_cnt_r <= 8'd0;
            end
        end
    end
    assign if_m1.resp  = m1_resp_r;
    assign if_m1.rdata = if_m1.address ^ 16'h2234;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t mk(input bit d, input bit wr, input lc3b_word a,
                                input lc3b_mem_wmask be, input lc3b_word wd);
        exp_t e;
        e.d = d; e.wr = wr; e.addr = a; e.be = be; e.wdata = wd;
        return e;
    endfunction

    // Scoreboard unit 0: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (if_i0.resp || if_d0.resp)) begin
            if (q0.size() == 0) begin
                check_val("u0_unexpected_resp", {30'd0, if_i0.resp, if_d0.resp}, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check_val("u0_port", {30'd0, if_i0.resp, if_d0.resp}, e0.d ? 32'd1 : 32'd2);
                check_val("u0_rw", {30'd0, if_m0.read, if_m0.write}, e0.wr ? 32'd1 : 32'd2);
                check_val("u0_addr", {16'd0, if_m0.address}, {16'd0, e0.addr});
                check_val("u0_be", {30'd0, if_m0.wmask}, {30'd0, e0.be});
                check_val("u0_wdata", {16'd0, if_m0.wdata}, {16'd0, e0.wdata});
                check_val("u0_rdata", {16'd0, e0.d ? if_d0.rdata : if_i0.rdata},
                          {16'd0, e0.addr ^ 16'h2234});
            end
        end
    end

    // Scoreboard unit 1: grant order and payload.
    always @(negedge clk) begin
        if (rst_n && (if_i1.resp || if_d1.resp)) begin
            if (q1.size() == 0) begin
                check_val("u1_unexpected_resp", {30'd0, if_i1.resp, if_d1.resp}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check_val("u1_port", {30'd0, if_i1.resp, if_d1.resp}, e1.d ? 32'd1 : 32'd2);
                check_val("u1_addr", {16'd0, if_m1.address}, {16'd0, e1.addr});
                check_val("u1_rdata", {16'd0, e1.d ? if_d1.rdata : if_i1.rdata},
                          {16'd0, e1.addr ^ 16'h2234});
            end
        end
    end

    task automatic fetch(input int u, input lc3b_word a);
        bit got;
        got = 1'b0;
        if (u == 0) begin if_i0.read = 1'b1; if_i0.address = a; end
        else begin if_i1.read = 1'b1; if_i1.address = a; end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((u == 0) ? if_i0.resp : if_i1.resp) begin
                got = 1'b1;
                break;
            end
        end
        check_val("i_resp_within_bound", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (u == 0) if_i0.read = 1'b0;
        else if_i1.read = 1'b0;
    endtask

    task automatic dreq(input int u, input bit wr, input lc3b_word a,
                        input lc3b_word wd, input lc3b_mem_wmask be);
        bit got;
        got = 1'b0;
        if (u == 0) begin
            if_d0.read = !wr; if_d0.write = wr; if_d0.address = a; if_d0.wdata = wd; if_d0.wmask = be;
        end else begin
            if_d1.read = !wr; if_d1.write = wr; if_d1.address = a; if_d1.wdata = wd; if_d1.wmask = be;
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((u == 0) ? if_d0.resp : if_d1.resp) begin
                got = 1'b1;
                break;
            end
        end
        check_val("d_resp_within_bound", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        if (u == 0) begin if_d0.read = 1'b0; if_d0.write = 1'b0; end
        else begin if_d1.read = 1'b0; if_d1.write = 1'b0; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; m_en = 1'b1; stray = 1'b0;
        if_i0.read = 1'b0; if_i0.write = 1'b0; if_i0.wmask = 2'b00; if_i0.address = 16'h0000; if_i0.wdata = 16'h0000;
        if_i1.read = 1'b0; if_i1.write = 1'b0; if_i1.wmask = 2'b00; if_i1.address = 16'h0000; if_i1.wdata = 16'h0000;
        if_d0.read = 1'b0; if_d0.write = 1'b0; if_d0.wmask = 2'b00; if_d0.address = 16'h0000; if_d0.wdata = 16'h0000;
        if_d1.read = 1'b0; if_d1.write = 1'b0; if_d1.wmask = 2'b00; if_d1.address = 16'h0000; if_d1.wdata = 16'h0000;

        // Reset values.
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, busy0}, 32'd0);
        check_val("rst_rw", {30'd0, if_m0.read, if_m0.write}, 32'd0);
        check_val("rst_be", {30'd0, if_m0.wmask}, 32'd3);
        check_val("rst_addr", {16'd0, if_m0.address}, 32'd0);
        check_val("rst_err", {31'd0, err0}, 32'd0);
        check_val("rst_resp", {30'd0, if_i0.resp, if_d0.resp}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Lone fetch: mem_read rises one cycle after the request.
        q0.push_back(mk(1'b0, 1'b0, 16'h3000, 2'b11, 16'h0000));
        fork
            fetch(0, 16'h3000);
            begin
                @(negedge clk);
                check_val("lat_req_cycle_mem_read", {31'd0, if_m0.read}, 32'd0);
                @(negedge clk);
                check_val("lat_next_cycle_mem_read", {31'd0, if_m0.read}, 32'd1);
                check_val("lat_next_cycle_addr", {16'd0, if_m0.address}, 32'h3000);
            end
        join

        // Round-robin collision (last grant = I): D, then I, then D again.
        q0.push_back(mk(1'b1, 1'b1, 16'h4000, 2'b01, 16'hBEEF));
        q0.push_back(mk(1'b0, 1'b0, 16'h5000, 2'b11, 16'h0000));
        q0.push_back(mk(1'b1, 1'b1, 16'h4002, 2'b10, 16'hCAFE));
        fork
            begin
                dreq(0, 1'b1, 16'h4000, 16'hBEEF, 2'b01);
                dreq(0, 1'b1, 16'h4002, 16'hCAFE, 2'b10);
            end
            fetch(0, 16'h5000);
        join

        // Stray mem_resp while idle is swallowed.
        stray = 1'b1;
        @(negedge clk);
        check_val("stray_resp", {30'd0, if_i0.resp, if_d0.resp}, 32'd0);
        check_val("stray_busy", {31'd0, busy0}, 32'd0);
        @(posedge clk); #1;
        stray = 1'b0;

        // Granted d_read withdrawn before memory answers.
        m_en = 1'b0;
        if_d0.read = 1'b1; if_d0.address = 16'h6000;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_granted_read", {31'd0, if_m0.read}, 32'd1);
        @(posedge clk); #1;
        if_d0.read = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_busy", {31'd0, busy0}, 32'd0);
        check_val("abort_mem_read", {31'd0, if_m0.read}, 32'd0);
        @(posedge clk); #1;

        // Watchdog: silent memory for 8 grant cycles, then a late response.
        q0.push_back(mk(1'b0, 1'b0, 16'h7000, 2'b11, 16'h0000));
        fork
            fetch(0, 16'h7000);
            begin
                @(negedge clk);
                for (int g = 1; g <= 8; g++) begin
                    @(negedge clk);
                    check_val($sformatf("wd_pre_%0d", g), {31'd0, err0}, 32'd0);
                end
                @(negedge clk);
                check_val("wd_set", {31'd0, err0}, 32'd1);
                check_val("wd_grant_held", {31'd0, busy0}, 32'd1);
                repeat (3) @(negedge clk);
                check_val("wd_sticky", {31'd0, err0}, 32'd1);
                @(posedge clk); #1;
                m_en = 1'b1;
            end
        join
        check_val("wd_after_completion", {31'd0, err0}, 32'd1);

        // Fixed priority: D keeps winning while it re-requests back-to-back.
        q1.push_back(mk(1'b1, 1'b1, 16'h8000, 2'b11, 16'h0001));
        q1.push_back(mk(1'b1, 1'b1, 16'h8002, 2'b11, 16'h0002));
        q1.push_back(mk(1'b1, 1'b1, 16'h8004, 2'b11, 16'h0003));
        q1.push_back(mk(1'b0, 1'b0, 16'h9000, 2'b11, 16'h0000));
        fork
            begin
                dreq(1, 1'b1, 16'h8000, 16'h0001, 2'b11);
                dreq(1, 1'b1, 16'h8002, 16'h0002, 2'b11);
                dreq(1, 1'b1, 16'h8004, 16'h0003, 2'b11);
            end
            fetch(1, 16'h9000);
        join

        // Reset in the middle of a data write.
        m_en = 1'b0;
        if_d0.write = 1'b1; if_d0.address = 16'h4100; if_d0.wdata = 16'h1111; if_d0.wmask = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_mid_pre_write", {31'd0, if_m0.write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_mem_write", {31'd0, if_m0.write}, 32'd0);
        check_val("rst_mid_busy", {31'd0, busy0}, 32'd0);
        check_val("rst_mid_err", {31'd0, err0}, 32'd0);
        if_d0.write = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_en = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", {31'd0, busy0}, 32'd0);
        check_val("post_rst_err", {31'd0, err0}, 32'd0);
        @(posedge clk); #1;

        // Normal service resumes after reset.
        q0.push_back(mk(1'b0, 1'b0, 16'h3002, 2'b11, 16'h0000));
        fetch(0, 16'h3002);

        repeat (3) @(posedge clk);
        check_val("q0_drained", q0.size(), 32'd0);
        check_val("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
